// File: rtl/router_wr_ctrl.sv
// Ingress write controller for the 1x3 router: decodes the header, sequences FIFO writes,
// checks packet parity and runs a per-port read watchdog that flushes stale FIFOs.
module router_wr_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int TIMER_W = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] wr_enb,
  output logic       lfd_state,
  output logic [7:0] fifo_din,
  output logic [2:0] vld_out,
  output logic [2:0] soft_rst,
  output logic       parity_done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK, DROP
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  state_t             state;
  logic [7:0]         header;
  logic [7:0]         parity_acc;
  logic [1:0]         addr;
  logic [6:0]         remaining;   // bytes still to come after the header (payload + parity)
  logic               mismatch;
  logic [TIMER_W-1:0] timer [3];

  logic [3:0] full_ext, empty_ext, srst_ext;
  logic       sel_full, sel_empty, sel_srst;
  logic       stall, wr_hit, lfd, transfer, in_load;

  // Address 3 maps onto a constant-zero slot so selects never go out of range.
  assign full_ext  = {1'b0, fifo_full};
  assign empty_ext = {1'b0, fifo_empty};
  assign srst_ext  = {1'b0, soft_rst};
  assign sel_full  = full_ext[addr];
  assign sel_empty = empty_ext[addr];
  assign sel_srst  = srst_ext[addr];

  assign vld_out  = ~fifo_empty;
  assign transfer = pkt_valid && !busy;
  assign in_load  = (state == WAIT_EMPTY) || (state == LOAD_FIRST) ||
                    (state == LOAD_DATA)  || (state == LOAD_PARITY);

  // Stall and write strobes; a pending flush on our port blocks the write so it is dropped.
  always_comb begin
    stall  = 1'b1;
    wr_hit = 1'b0;
    lfd    = 1'b0;
    case (state)
      IDLE, DROP: stall = 1'b0;
      LOAD_FIRST: begin
        stall = 1'b1;
        if (!sel_full && !sel_srst) begin
          wr_hit = 1'b1;
          lfd    = 1'b1;
        end else begin
          wr_hit = 1'b0;
        end
      end
      LOAD_DATA, LOAD_PARITY: begin
        stall  = sel_full | sel_srst;
        wr_hit = pkt_valid && !(sel_full | sel_srst);
      end
      default: stall = 1'b1;
    endcase
  end

  assign busy      = rstn & stall;
  assign lfd_state = rstn & lfd;
  assign wr_enb    = (rstn && wr_hit) ? (3'b001 << addr) : 3'b000;
  assign fifo_din  = (state == LOAD_FIRST) ? header : data_in;

  // Packet sequencing, parity accumulation and error reporting.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      header      <= 8'd0;
      addr        <= 2'd0;
      remaining   <= 7'd0;
      parity_acc  <= 8'd0;
      mismatch    <= 1'b0;
      err         <= 1'b0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= 1'b0;
      if (in_load && sel_srst) begin
        err   <= 1'b1;
        state <= DROP;
      end else begin
        case (state)
          IDLE: if (transfer) begin
            header     <= data_in;
            addr       <= data_in[1:0];
            remaining  <= {1'b0, data_in[7:2]} + 7'd1;
            parity_acc <= data_in;
            err        <= 1'b0;
            if (data_in[1:0] == 2'd3)          state <= DROP;
            else if (empty_ext[data_in[1:0]]) state <= LOAD_FIRST;
            else                               state <= WAIT_EMPTY;
          end
          WAIT_EMPTY: if (sel_empty) state <= LOAD_FIRST;
          LOAD_FIRST: if (!sel_full) state <= (remaining == 7'd1) ? LOAD_PARITY : LOAD_DATA;
          LOAD_DATA: if (transfer) begin
            remaining  <= remaining - 7'd1;
            parity_acc <= parity_acc ^ data_in;
            if (remaining == 7'd2) state <= LOAD_PARITY;
          end
          LOAD_PARITY: if (transfer) begin
            remaining   <= 7'd0;
            mismatch    <= (data_in != parity_acc);
            parity_done <= 1'b1;
            state       <= CHECK;
          end
          CHECK: begin
            err   <= mismatch;
            state <= IDLE;
          end
          DROP: begin
            if (remaining == 7'd0) begin
              parity_done <= 1'b1;
              state       <= IDLE;
            end else if (transfer) begin
              remaining <= remaining - 7'd1;
              if (remaining == 7'd1) begin
                parity_done <= 1'b1;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Per-port read watchdogs: flush a FIFO whose data has sat unread for TIMEOUT cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn) begin
        timer[i]    <= '0;
        soft_rst[i] <= 1'b0;
      end else if (vld_out[i] && !read_enb[i]) begin
        if (timer[i] == TIMER_LAST) begin
          timer[i]    <= '0;
          soft_rst[i] <= 1'b1;
        end else begin
          timer[i]    <= timer[i] + TIMER_ONE;
          soft_rst[i] <= 1'b0;
        end
      end else begin
        timer[i]    <= '0;
        soft_rst[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_wr_ctrl.sv
// Scoreboard bench for router_wr_ctrl: frames are described as byte lists, expected FIFO
// writes and packet outcomes are queued at issue time and checked by independent monitors.
module tb_router_wr_ctrl;
  logic       clk, rstn, pkt_valid, busy, lfd_state, parity_done, err;
  logic [7:0] data_in, fifo_din;
  logic [2:0] fifo_full, fifo_empty, read_enb, wr_enb, vld_out, soft_rst;

  router_wr_ctrl dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb), .wr_enb(wr_enb),
    .lfd_state(lfd_state), .fifo_din(fifo_din), .vld_out(vld_out), .soft_rst(soft_rst),
    .parity_done(parity_done), .err(err)
  );

  typedef struct { logic [1:0] port; logic [7:0] data; logic lfd; } wr_t;
  wr_t        exp_wr[$];
  logic       exp_done[$];
  logic [7:0] frame[$];
  int         tests = 0, fails = 0;
  bit         rand_full_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls);
    stalls = 0;
    pkt_valid = 1'b1;
    data_in = b;
    @(negedge clk);
    while (busy && stalls < 200) begin
      stalls++;
      tick();
      @(negedge clk);
    end
    if (busy) check("send_timeout", 32'd1, 32'd0);
    tick();
    pkt_valid = 1'b0;
  endtask

  // Expected outcome comes straight from the frame rules: a valid port gets every byte in
  // order with lfd on the header; err means the last byte differs from the XOR of the rest.
  task automatic send_frame(input bit gaps, input bit chk_clear);
    logic [1:0] port;
    logic [7:0] x;
    int st;
    port = frame[0][1:0];
    x = 8'd0;
    for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
    if (port != 2'd3)
      for (int i = 0; i < frame.size(); i++) exp_wr.push_back('{port, frame[i], (i == 0)});
    exp_done.push_back((port != 2'd3) && (frame[frame.size()-1] != x));
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 2)) tick();
      send_byte(frame[i], st);
      if (i == 0 && chk_clear) begin
        @(negedge clk);
        check("err_clear_on_header", err, 1'b0);
        tick();
      end
    end
    repeat (2) tick();
  endtask

  // Write monitor: every strobe must match the head of the expected-write queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (lfd_state && wr_enb == 3'b000) check("lfd_without_write", 32'd1, 32'd0);
      if (wr_enb != 3'b000) begin
        check("write_while_full", {29'd0, wr_enb & fifo_full}, 32'd0);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {21'd0, wr_enb, fifo_din}, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_enb", {29'd0, wr_enb}, {29'd0, 3'b001 << e.port});
          check("fifo_din", {24'd0, fifo_din}, {24'd0, e.data});
          check("lfd_state", {31'd0, lfd_state}, {31'd0, e.lfd});
        end
      end
    end
  end

  // Outcome monitor: each parity_done pulse pops an expected err, checked a cycle later.
  initial begin
    bit   pend;
    logic e;
    pend = 0;
    e = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) check("err_after_done", {31'd0, err}, {31'd0, e});
      pend = 0;
      if (rstn && parity_done) begin
        if (exp_done.size() == 0) check("unexpected_parity_done", 32'd1, 32'd0);
        else begin
          e = exp_done.pop_front();
          pend = 1;
        end
      end
    end
  end

  // Watchdog model: 30 consecutive unread-but-valid cycles yield a pulse in the next cycle.
  initial begin
    int run[3];
    bit expp[3];
    for (int i = 0; i < 3; i++) begin run[i] = 0; expp[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rstn) begin
          run[i] = 0;
          expp[i] = 0;
        end else begin
          if (soft_rst[i] || expp[i]) check("soft_rst", {31'd0, soft_rst[i]}, {31'd0, expp[i]});
          expp[i] = 0;
          if (!fifo_empty[i] && !read_enb[i]) begin
            run[i]++;
            if (run[i] == 30) begin expp[i] = 1; run[i] = 0; end
          end else run[i] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_full_en) fifo_full = 3'($urandom_range(7)) & 3'($urandom_range(7));
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int st, found, len, stall_sum;
    logic [1:0] port;
    logic [7:0] x;
    rstn = 1'b0; pkt_valid = 1'b0; data_in = 8'd0;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b111;
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_outputs", {24'd0, wr_enb, lfd_state, parity_done, err, soft_rst}, 32'd0);
    tick();

    frame = '{8'h09, 8'hA5, 8'h3C, 8'h90};   send_frame(0, 0);
    frame = '{8'h09, 8'hA5, 8'h3C, 8'h91};   send_frame(0, 0);
    frame = '{8'h09, 8'hA5, 8'h3C, 8'h90};   send_frame(0, 1);

    // Stall mid-payload on a full FIFO.
    frame = '{8'h09, 8'hA5, 8'h3C, 8'h90};
    foreach (frame[i]) exp_wr.push_back('{2'd1, frame[i], (i == 0)});
    exp_done.push_back(1'b0);
    send_byte(8'h09, st);
    send_byte(8'hA5, st);
    fifo_full[1] = 1'b1; pkt_valid = 1'b1; data_in = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_stall_busy", {31'd0, busy}, 32'd1);
      check("full_stall_wr", {29'd0, wr_enb}, 32'd0);
      tick();
    end
    fifo_full[1] = 1'b0;
    send_byte(8'h3C, st);
    send_byte(8'h90, st);
    repeat (2) tick();

    // Zero-length packet waiting for a non-empty FIFO to drain.
    fifo_empty[2] = 1'b0;
    exp_wr.push_back('{2'd2, 8'h02, 1'b1});
    exp_wr.push_back('{2'd2, 8'h02, 1'b0});
    exp_done.push_back(1'b0);
    send_byte(8'h02, st);
    pkt_valid = 1'b1; data_in = 8'h02;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("wait_empty_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    fifo_empty[2] = 1'b1;
    send_byte(8'h02, st);
    repeat (2) tick();

    // Invalid address: consumed without stalls or writes.
    exp_done.push_back(1'b0);
    stall_sum = 0;
    foreach (frame[i]) ;
    send_byte(8'h07, st); stall_sum += st;
    send_byte(8'h11, st); stall_sum += st;
    send_byte(8'h22, st); stall_sum += st;
    check("drop_no_stall", stall_sum, 32'd0);
    repeat (2) tick();

    // Watchdog on an idle port.
    fifo_empty[0] = 1'b0; read_enb[0] = 1'b0;
    found = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (soft_rst[0]) begin found = c; break; end
      tick();
    end
    check("watchdog_cycle", found, 32'd31);
    tick();
    fifo_empty[0] = 1'b1; read_enb[0] = 1'b1;
    repeat (2) tick();

    // Watchdog abort mid-packet: only the header reaches FIFO0.
    exp_wr.push_back('{2'd0, 8'h04, 1'b1});
    exp_done.push_back(1'b1);
    send_byte(8'h04, st);
    tick();
    fifo_empty[0] = 1'b0; read_enb[0] = 1'b0;
    repeat (35) tick();
    @(negedge clk);
    check("abort_err", {31'd0, err}, 32'd1);
    tick();
    fifo_empty[0] = 1'b1; read_enb[0] = 1'b1;
    send_byte(8'h11, st);
    send_byte(8'h15, st);
    repeat (2) tick();

    // Reset mid-packet.
    exp_wr.push_back('{2'd1, 8'h0D, 1'b1});
    exp_wr.push_back('{2'd1, 8'h44, 1'b0});
    send_byte(8'h0D, st);
    send_byte(8'h44, st);
    rstn = 1'b0; pkt_valid = 1'b1; data_in = 8'h55;
    @(negedge clk);
    check("reset_mid_wr", {29'd0, wr_enb}, 32'd0);
    repeat (2) tick();
    rstn = 1'b1; pkt_valid = 1'b0;
    @(negedge clk);
    check("reset_mid_err", {30'd0, err, parity_done}, 32'd0);
    tick();
    frame = '{8'h05, 8'h5A, 8'h5F};   send_frame(0, 0);

    // Randomised frames with source gaps and full-flag noise.
    rand_full_en = 1;
    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(0, 12);
      port = 2'($urandom_range(0, 3));
      frame.delete();
      frame.push_back({6'(len), port});
      x = {6'(len), port};
      for (int i = 0; i < len; i++) begin
        frame.push_back(8'($urandom_range(255)));
        x ^= frame[frame.size()-1];
      end
      if ($urandom_range(3) == 0) x ^= 8'h01 << $urandom_range(7);
      frame.push_back(x);
      send_frame(1, 0);
    end
    rand_full_en = 0;
    tick();
    fifo_full = 3'b000;
    repeat (4) tick();

    check("leftover_writes", exp_wr.size(), 32'd0);
    check("leftover_done", exp_done.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
